// File: rtl/aes_xif_result_queue_pkg.sv
// -----------------------------------------------------------------------------
// aes_coproc_pkg
// Shared types for the AES coprocessor XIF result queue.
//   XIF_ID_WIDTH / XIF_RFW_WIDTH : default id and result-data widths
//   RD_WIDTH                     : destination register index width
//   aes_res_entry_t              : one queued result {id, rd, we, data}
//   head_state_e                 : what the queue does with its head entry
//   head_state_decode()          : maps the per-id commit/kill bits to a state
// -----------------------------------------------------------------------------
package aes_coproc_pkg;

    localparam int XIF_ID_WIDTH  = 4;
    localparam int XIF_RFW_WIDTH = 32;
    localparam int RD_WIDTH      = 5;

    typedef struct packed {
        logic [XIF_ID_WIDTH-1:0]  id;
        logic [RD_WIDTH-1:0]      rd;
        logic                     we;
        logic [XIF_RFW_WIDTH-1:0] data;
    } aes_res_entry_t;

    typedef enum logic [1:0] {
        HEAD_WAIT = 2'd0,
        HEAD_SEND = 2'd1,
        HEAD_DROP = 2'd2
    } head_state_e;

    // Uncommitted ids wait; committed ids are either sent or silently dropped.
    function automatic head_state_e head_state_decode(input logic cmt, input logic kil);
        head_state_e st;
        case ({cmt, kil})
            2'b10:   st = HEAD_SEND;
            2'b11:   st = HEAD_DROP;
            default: st = HEAD_WAIT;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/aes_xif_result_queue_if.sv
// -----------------------------------------------------------------------------
// aes_xif_result_queue_if
// Bundles the three channels seen by the result queue:
//   eng_*    : AES engine result push (valid/ready + payload)
//   commit_* : XIF commit/kill strobe
//   result_* : XIF result handshake (valid/ready + payload)
//   count_o  : queue occupancy
// Modport slave is the queue's view, modport master the environment's view.
// -----------------------------------------------------------------------------
interface aes_xif_result_queue_if #(
    parameter int X_ID_WIDTH  = 4,
    parameter int X_RFW_WIDTH = 32,
    parameter int DEPTH       = 4
) ();

    logic                         eng_valid_i;
    logic                         eng_ready_o;
    logic [X_ID_WIDTH-1:0]        eng_id_i;
    logic [4:0]                   eng_rd_i;
    logic                         eng_we_i;
    logic [X_RFW_WIDTH-1:0]       eng_data_i;

    logic                         commit_valid_i;
    logic [X_ID_WIDTH-1:0]        commit_id_i;
    logic                         commit_kill_i;

    logic                         result_valid_o;
    logic                         result_ready_i;
    logic [X_ID_WIDTH-1:0]        result_id_o;
    logic [4:0]                   result_rd_o;
    logic                         result_we_o;
    logic [X_RFW_WIDTH-1:0]       result_data_o;

    logic [$clog2(DEPTH+1)-1:0]   count_o;

    modport slave (
        input  eng_valid_i, eng_id_i, eng_rd_i, eng_we_i, eng_data_i,
        output eng_ready_o,
        input  commit_valid_i, commit_id_i, commit_kill_i,
        output result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o,
        input  result_ready_i,
        output count_o
    );

    modport master (
        output eng_valid_i, eng_id_i, eng_rd_i, eng_we_i, eng_data_i,
        input  eng_ready_o,
        output commit_valid_i, commit_id_i, commit_kill_i,
        input  result_valid_o, result_id_o, result_rd_o, result_we_o, result_data_o,
        output result_ready_i,
        input  count_o
    );

endinterface

// File: rtl/aes_xif_result_queue_fifo.sv
// -----------------------------------------------------------------------------
// aes_resq_fifo
// Synchronous circular FIFO of aes_res_entry_t.
//   clk_i, rst_i : clock, synchronous active-high reset (pointers only)
//   push_i/data_i: write data_i at the tail (ignored when full)
//   pop_i        : drop the head entry (ignored when empty)
//   head_o       : entry at the read pointer
//   count_o      : occupied entries; full_o / empty_o status
// Pointers carry one extra MSB so full and empty are distinguishable; they
// wrap modulo 2*DEPTH.
// -----------------------------------------------------------------------------
module aes_resq_fifo
    import aes_coproc_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  aes_res_entry_t           data_i,
    input  logic                     pop_i,
    output aes_res_entry_t           head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    aes_res_entry_t  mem_r [DEPTH];
    logic [PW-1:0]   wptr_r;
    logic [PW-1:0]   rptr_r;
    logic            full_s;
    logic            empty_s;
    logic            do_push_s;
    logic            do_pop_s;

    assign full_s    = (wptr_r[AW] != rptr_r[AW]) && (wptr_r[AW-1:0] == rptr_r[AW-1:0]);
    assign empty_s   = (wptr_r == rptr_r);
    assign do_push_s = push_i && !full_s;
    assign do_pop_s  = pop_i && !empty_s;

    // Read/write pointer update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_r <= {PW{1'b0}};
            rptr_r <= {PW{1'b0}};
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + PW'(1);
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + PW'(1);
            end
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk_i) begin
        if (do_push_s) begin
            mem_r[wptr_r[AW-1:0]] <= data_i;
        end
    end

    assign head_o  = mem_r[rptr_r[AW-1:0]];
    assign count_o = wptr_r - rptr_r;
    assign full_o  = full_s;
    assign empty_o = empty_s;

endmodule

// File: rtl/aes_xif_result_queue.sv
// -----------------------------------------------------------------------------
// aes_xif_result_queue
// In-order buffer between the AES datapath and the XIF result channel.
//   clk_i : clock
//   rst_i : synchronous active-high reset; drops all queued entries and
//           all commit/kill knowledge
//   bus   : aes_xif_result_queue_if.slave (engine push, commit strobe,
//           result handshake, occupancy)
// Results are held until their id is committed (sent on the result channel)
// or killed (popped silently, one cycle per entry).
// Optional build macro AES_RESQ_BYPASS_EN: when the queue is empty and the
// incoming result is already committed, it is presented combinationally in
// the same cycle; it is only stored if the consumer is not ready.
// -----------------------------------------------------------------------------
module aes_xif_result_queue
    import aes_coproc_pkg::*;
#(
    parameter int X_ID_WIDTH  = XIF_ID_WIDTH,
    parameter int X_RFW_WIDTH = XIF_RFW_WIDTH,
    parameter int DEPTH       = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    aes_xif_result_queue_if.slave   bus
);

    localparam int NUM_IDS = 2 ** X_ID_WIDTH;
    localparam int CNT_W   = $clog2(DEPTH + 1);

    logic [NUM_IDS-1:0]       cmt_r;
    logic [NUM_IDS-1:0]       kil_r;

    aes_res_entry_t           push_entry_s;
    aes_res_entry_t           head_entry_s;
    logic                     push_s;
    logic                     pop_s;
    logic                     full_s;
    logic                     empty_s;
    logic [CNT_W-1:0]         count_s;
    logic                     eng_ready_s;
    logic                     bypass_s;
    head_state_e              head_state_s;

    logic                     clr_valid_s;
    logic [X_ID_WIDTH-1:0]    clr_id_s;

    logic                     res_valid_s;
    logic [X_ID_WIDTH-1:0]    res_id_s;
    logic [RD_WIDTH-1:0]      res_rd_s;
    logic                     res_we_s;
    logic [X_RFW_WIDTH-1:0]   res_data_s;

    assign push_entry_s.id   = bus.eng_id_i;
    assign push_entry_s.rd   = bus.eng_rd_i;
    assign push_entry_s.we   = bus.eng_we_i;
    assign push_entry_s.data = bus.eng_data_i;

    assign eng_ready_s = !full_s && !rst_i;

    aes_resq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_s),
        .data_i  (push_entry_s),
        .pop_i   (pop_s),
        .head_o  (head_entry_s),
        .count_o (count_s),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

`ifdef AES_RESQ_BYPASS_EN
    // Only ids committed in an earlier cycle qualify; a same-cycle commit
    // still goes through the queue.
    assign bypass_s = empty_s && eng_ready_s && bus.eng_valid_i &&
                      cmt_r[bus.eng_id_i] && !kil_r[bus.eng_id_i];
`else
    assign bypass_s = 1'b0;
`endif

    // Classify the head entry from the registered commit/kill bits.
    always_comb begin
        head_state_s = HEAD_WAIT;
        if (empty_s) begin
            head_state_s = HEAD_WAIT;
        end else begin
            head_state_s = head_state_decode(cmt_r[head_entry_s.id], kil_r[head_entry_s.id]);
        end
    end

    // Result presentation, pop and per-id clear decisions.
    always_comb begin
        res_valid_s = 1'b0;
        res_id_s    = {X_ID_WIDTH{1'b0}};
        res_rd_s    = {RD_WIDTH{1'b0}};
        res_we_s    = 1'b0;
        res_data_s  = {X_RFW_WIDTH{1'b0}};
        pop_s       = 1'b0;
        clr_valid_s = 1'b0;
        clr_id_s    = {X_ID_WIDTH{1'b0}};
        if (bypass_s) begin
            res_valid_s = 1'b1;
            res_id_s    = bus.eng_id_i;
            res_rd_s    = bus.eng_rd_i;
            res_we_s    = bus.eng_we_i;
            res_data_s  = bus.eng_data_i;
            clr_valid_s = bus.result_ready_i;
            clr_id_s    = bus.eng_id_i;
        end else begin
            case (head_state_s)
                HEAD_SEND: begin
                    res_valid_s = 1'b1;
                    res_id_s    = head_entry_s.id;
                    res_rd_s    = head_entry_s.rd;
                    res_we_s    = head_entry_s.we;
                    res_data_s  = head_entry_s.data;
                    pop_s       = bus.result_ready_i;
                    clr_valid_s = bus.result_ready_i;
                    clr_id_s    = head_entry_s.id;
                end
                HEAD_DROP: begin
                    pop_s       = 1'b1;
                    clr_valid_s = 1'b1;
                    clr_id_s    = head_entry_s.id;
                end
                default: begin
                    pop_s       = 1'b0;
                end
            endcase
        end
    end

    // A bypassed result that is accepted at once never enters the queue.
    always_comb begin
        push_s = 1'b0;
        if (bypass_s && bus.result_ready_i) begin
            push_s = 1'b0;
        end else begin
            push_s = bus.eng_valid_i && eng_ready_s;
        end
    end

    // Per-id commit/kill bits; a same-cycle commit overrides the pop clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cmt_r <= {NUM_IDS{1'b0}};
            kil_r <= {NUM_IDS{1'b0}};
        end else begin
            if (clr_valid_s) begin
                cmt_r[clr_id_s] <= 1'b0;
                kil_r[clr_id_s] <= 1'b0;
            end
            if (bus.commit_valid_i) begin
                cmt_r[bus.commit_id_i] <= 1'b1;
                kil_r[bus.commit_id_i] <= bus.commit_kill_i;
            end
        end
    end

    assign bus.eng_ready_o    = eng_ready_s;
    assign bus.result_valid_o = res_valid_s;
    assign bus.result_id_o    = res_id_s;
    assign bus.result_rd_o    = res_rd_s;
    assign bus.result_we_o    = res_we_s;
    assign bus.result_data_o  = res_data_s;
    assign bus.count_o        = count_s;

endmodule

// File: tb/tb_aes_xif_result_queue.sv
// -----------------------------------------------------------------------------
// tb_aes_xif_result_queue
// Directed cycle table, hand-written stall/reset sequences and a randomized
// run against a queue-based reference model of the result buffer.
// -----------------------------------------------------------------------------
module tb_aes_xif_result_queue;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    aes_xif_result_queue_if #(.X_ID_WIDTH(4), .X_RFW_WIDTH(32), .DEPTH(DEPTH)) bus ();

    aes_xif_result_queue #(.X_ID_WIDTH(4), .X_RFW_WIDTH(32), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_bad = 0;

    typedef struct {
        bit ev; int eid; int erd; bit ewe; logic [31:0] edata;
        bit cv; int cid; bit ck; bit rdy;
        bit xv; int xid; int xrd; bit xwe; logic [31:0] xdata;
        int xcnt; bit xer;
    } vec_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] data;
    } ent_t;

    vec_t vecs[$];

    // reference model state
    ent_t mq[$];
    bit   m_cmt[16];
    bit   m_kil[16];
    bit   busy[16];
    bit   tcmt[16];

    // random stimulus state
    bit   cur_ev;
    ent_t cur_e;
    bit   r_cv;
    int   r_cid;
    bit   r_ck;
    bit   r_rdy;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit ev, input int eid, input int erd, input bit ewe,
                         input logic [31:0] edata, input bit cv, input int cid,
                         input bit ck, input bit rdy);
        bus.eng_valid_i    = ev;
        bus.eng_id_i       = 4'(eid);
        bus.eng_rd_i       = 5'(erd);
        bus.eng_we_i       = ewe;
        bus.eng_data_i     = edata;
        bus.commit_valid_i = cv;
        bus.commit_id_i    = 4'(cid);
        bus.commit_kill_i  = ck;
        bus.result_ready_i = rdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(bit ev, int eid, int erd, bit ewe, logic [31:0] edata,
                                bit cv, int cid, bit ck, bit rdy,
                                bit xv, int xid, int xrd, bit xwe, logic [31:0] xdata,
                                int xcnt, bit xer);
        vec_t v;
        v.ev = ev; v.eid = eid; v.erd = erd; v.ewe = ewe; v.edata = edata;
        v.cv = cv; v.cid = cid; v.ck = ck; v.rdy = rdy;
        v.xv = xv; v.xid = xid; v.xrd = xrd; v.xwe = xwe; v.xdata = xdata;
        v.xcnt = xcnt; v.xer = xer;
        return v;
    endfunction

    task automatic chk_payload(input string tag, input int id, input int rd,
                               input bit we, input logic [31:0] data);
        chk({tag, " id"},   64'(bus.result_id_o),   64'(id));
        chk({tag, " rd"},   64'(bus.result_rd_o),   64'(rd));
        chk({tag, " we"},   64'(bus.result_we_o),   64'(we));
        chk({tag, " data"}, 64'(bus.result_data_o), 64'(data));
    endtask

    // One model cycle: compare DUT outputs with the model, then advance it.
    task automatic model_step(input int cyc);
        bit   xv;
        bit   xer;
        bit   pop;
        bit   byp;
        bit   acc;
        int   fid;
        ent_t xe;
        ent_t h;
        xv  = 1'b0;
        pop = 1'b0;
        byp = 1'b0;
        fid = -1;
        xe  = '0;
        if (mq.size() != 0) begin
            h = mq[0];
            if (m_cmt[h.id] && !m_kil[h.id]) begin
                xv = 1'b1;
                xe = h;
                pop = r_rdy;
            end else if (m_cmt[h.id]) begin
                pop = 1'b1;
            end
        end
`ifdef AES_RESQ_BYPASS_EN
        else if (cur_ev && m_cmt[cur_e.id] && !m_kil[cur_e.id]) begin
            xv  = 1'b1;
            xe  = cur_e;
            byp = r_rdy;
        end
`endif
        xer = (mq.size() < DEPTH);
        chk($sformatf("rnd%0d valid", cyc), 64'(bus.result_valid_o), 64'(xv));
        chk($sformatf("rnd%0d count", cyc), 64'(bus.count_o), 64'(mq.size()));
        chk($sformatf("rnd%0d eng_ready", cyc), 64'(bus.eng_ready_o), 64'(xer));
        if (xv || mq.size() == 0) begin
            chk_payload($sformatf("rnd%0d", cyc), int'(xe.id), int'(xe.rd), xe.we, xe.data);
        end
        acc = cur_ev && xer && !byp;
        if (pop) begin
            h   = mq.pop_front();
            fid = int'(h.id);
        end
        if (byp) begin
            fid = int'(cur_e.id);
        end
        if (fid >= 0) begin
            m_cmt[fid] = 1'b0;
            m_kil[fid] = 1'b0;
            busy[fid]  = 1'b0;
            tcmt[fid]  = 1'b0;
        end
        if (acc) begin
            mq.push_back(cur_e);
        end
        if (r_cv) begin
            m_cmt[r_cid] = 1'b1;
            m_kil[r_cid] = r_ck;
        end
        if (acc || byp) begin
            cur_ev = 1'b0;
        end
    endtask

    task automatic random_cycle(input int cyc, input bit draining);
        int  id;
        int  start;
        bit  found;
        if (!cur_ev && !draining && $urandom_range(0, 99) < 55) begin
            start = $urandom_range(0, 15);
            found = 1'b0;
            for (int j = 0; j < 16; j++) begin
                id = (start + j) % 16;
                if (!found && !busy[id]) begin
                    found        = 1'b1;
                    busy[id]     = 1'b1;
                    cur_ev       = 1'b1;
                    cur_e.id     = 4'(id);
                    cur_e.rd     = 5'($urandom_range(0, 31));
                    cur_e.we     = 1'($urandom_range(0, 1));
                    cur_e.data   = $urandom;
                end
            end
        end
        r_cv  = 1'b0;
        r_cid = 0;
        r_ck  = ($urandom_range(0, 3) == 0);
        if (draining || $urandom_range(0, 99) < 40) begin
            start = $urandom_range(0, 15);
            for (int j = 0; j < 16; j++) begin
                id = (start + j) % 16;
                if (!r_cv && busy[id] && !tcmt[id]) begin
                    r_cv     = 1'b1;
                    r_cid    = id;
                    tcmt[id] = 1'b1;
                end
            end
        end
        r_rdy = draining ? 1'b1 : ($urandom_range(0, 3) != 0);
        drive(cur_ev, int'(cur_e.id), int'(cur_e.rd), cur_e.we, cur_e.data,
              r_cv, r_cid, r_ck, r_rdy);
        @(negedge clk);
        model_step(cyc);
        next_cycle();
    endtask

    initial begin
        vec_t v;

        // ---- directed cycle table (from empty, just out of reset) ----
        // A: push id3, then commit id3
        vecs.push_back(mk(1,3,7,1,32'h0000_00A5, 0,0,0, 1, 0,0,0,0,32'h0, 0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         1,3,0, 1, 0,0,0,0,32'h0, 1,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 1, 1,3,7,1,32'h0000_00A5, 1,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 1, 0,0,0,0,32'h0, 0,1));
        // B: commit id5 before its result
        vecs.push_back(mk(0,0,0,0,32'h0,         1,5,0, 1, 0,0,0,0,32'h0, 0,1));
`ifdef AES_RESQ_BYPASS_EN
        vecs.push_back(mk(1,5,2,1,32'h1234_5678, 0,0,0, 1, 1,5,2,1,32'h1234_5678, 0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 1, 0,0,0,0,32'h0, 0,1));
`else
        vecs.push_back(mk(1,5,2,1,32'h1234_5678, 0,0,0, 1, 0,0,0,0,32'h0, 0,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 1, 1,5,2,1,32'h1234_5678, 1,1));
`endif
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 1, 0,0,0,0,32'h0, 0,1));
        // C: push 1,2,3; kill 2; commit 1 and 3
        vecs.push_back(mk(1,1,1,1,32'h11,        0,0,0, 1, 0,0,0,0,32'h0, 0,1));
        vecs.push_back(mk(1,2,2,1,32'h22,        0,0,0, 1, 0,0,0,0,32'h0, 1,1));
        vecs.push_back(mk(1,3,3,0,32'h33,        1,2,1, 1, 0,0,0,0,32'h0, 2,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         1,1,0, 1, 0,0,0,0,32'h0, 3,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         1,3,0, 1, 1,1,1,1,32'h11, 3,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 1, 0,0,0,0,32'h0, 2,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 1, 1,3,3,0,32'h33, 1,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 1, 0,0,0,0,32'h0, 0,1));
        // D: fill to DEPTH with ready low, then drain; id8 refused while full
        vecs.push_back(mk(1,4,4,1,32'h40,        1,4,0, 0, 0,0,0,0,32'h0, 0,1));
        vecs.push_back(mk(1,5,5,1,32'h50,        1,5,0, 0, 1,4,4,1,32'h40, 1,1));
        vecs.push_back(mk(1,6,6,1,32'h60,        1,6,0, 0, 1,4,4,1,32'h40, 2,1));
        vecs.push_back(mk(1,7,7,1,32'h70,        1,7,0, 0, 1,4,4,1,32'h40, 3,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 0, 1,4,4,1,32'h40, 4,0));
        vecs.push_back(mk(1,8,8,1,32'h80,        0,0,0, 1, 1,4,4,1,32'h40, 4,0));
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 1, 1,5,5,1,32'h50, 3,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 1, 1,6,6,1,32'h60, 2,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 1, 1,7,7,1,32'h70, 1,1));
        vecs.push_back(mk(0,0,0,0,32'h0,         0,0,0, 1, 0,0,0,0,32'h0, 0,1));

        // ---- reset ----
        drive(0,0,0,0,32'h0, 0,0,0, 0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("reset eng_ready", 64'(bus.eng_ready_o), 64'd0);
        chk("reset count", 64'(bus.count_o), 64'd0);
        chk("reset valid", 64'(bus.result_valid_o), 64'd0);
        chk_payload("reset", 0, 0, 1'b0, 32'h0);
        next_cycle();
        rst = 1'b0;

        // ---- table ----
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.ev, v.eid, v.erd, v.ewe, v.edata, v.cv, v.cid, v.ck, v.rdy);
            @(negedge clk);
            chk($sformatf("vec%0d valid", i), 64'(bus.result_valid_o), 64'(v.xv));
            chk($sformatf("vec%0d count", i), 64'(bus.count_o), 64'(v.xcnt));
            chk($sformatf("vec%0d eng_ready", i), 64'(bus.eng_ready_o), 64'(v.xer));
            if (v.xv || v.xcnt == 0) begin
                chk_payload($sformatf("vec%0d", i), v.xid, v.xrd, v.xwe, v.xdata);
            end
            next_cycle();
        end

        // ---- stall: payload stable while ready low ----
        drive(1,9,9,0,32'hDEAD_BEEF, 1,9,0, 0);
        @(negedge clk);
        chk("stall push count", 64'(bus.count_o), 64'd0);
        next_cycle();
        drive(0,0,0,0,32'h0, 0,0,0, 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d valid", k), 64'(bus.result_valid_o), 64'd1);
            chk_payload($sformatf("stall%0d", k), 9, 9, 1'b0, 32'hDEAD_BEEF);
            next_cycle();
        end
        drive(0,0,0,0,32'h0, 0,0,0, 1);
        @(negedge clk);
        chk("stall accept valid", 64'(bus.result_valid_o), 64'd1);
        chk_payload("stall accept", 9, 9, 1'b0, 32'hDEAD_BEEF);
        next_cycle();
        @(negedge clk);
        chk("stall after valid", 64'(bus.result_valid_o), 64'd0);
        chk("stall after count", 64'(bus.count_o), 64'd0);
        next_cycle();

        // ---- reset mid-operation ----
        drive(1,10,1,1,32'hA0, 1,10,0, 0);
        next_cycle();
        drive(1,11,2,1,32'hB0, 1,11,0, 0);
        next_cycle();
        drive(1,12,3,1,32'hC0, 0,0,0, 0);
        next_cycle();
        drive(0,0,0,0,32'h0, 0,0,0, 0);
        @(negedge clk);
        chk("prerst count", 64'(bus.count_o), 64'd3);
        chk("prerst valid", 64'(bus.result_valid_o), 64'd1);
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst eng_ready", 64'(bus.eng_ready_o), 64'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("postrst valid", 64'(bus.result_valid_o), 64'd0);
        chk("postrst count", 64'(bus.count_o), 64'd0);
        chk("postrst eng_ready", 64'(bus.eng_ready_o), 64'd1);
        next_cycle();
        drive(1,10,1,1,32'h1010, 0,0,0, 1);
        next_cycle();
        drive(0,0,0,0,32'h0, 0,0,0, 1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("repush wait%0d valid", k), 64'(bus.result_valid_o), 64'd0);
            chk($sformatf("repush wait%0d count", k), 64'(bus.count_o), 64'd1);
            next_cycle();
        end
        drive(0,0,0,0,32'h0, 1,10,0, 1);
        @(negedge clk);
        chk("repush commit cycle valid", 64'(bus.result_valid_o), 64'd0);
        next_cycle();
        drive(0,0,0,0,32'h0, 0,0,0, 1);
        @(negedge clk);
        chk("repush send valid", 64'(bus.result_valid_o), 64'd1);
        chk_payload("repush send", 10, 1, 1'b1, 32'h1010);
        next_cycle();
        @(negedge clk);
        chk("repush done count", 64'(bus.count_o), 64'd0);
        next_cycle();

        // ---- randomized run against the reference model ----
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            m_cmt[i] = 1'b0;
            m_kil[i] = 1'b0;
            busy[i]  = 1'b0;
            tcmt[i]  = 1'b0;
        end
        mq.delete();
        cur_ev = 1'b0;
        cur_e  = '0;
        for (int c = 0; c < 3000; c++) begin
            random_cycle(c, 1'b0);
        end
        for (int c = 3000; c < 3080; c++) begin
            random_cycle(c, 1'b1);
        end
        drive(0,0,0,0,32'h0, 0,0,0, 1);
        @(negedge clk);
        chk("drain count", 64'(bus.count_o), 64'd0);
        chk("drain valid", 64'(bus.result_valid_o), 64'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_xif_result_queue.md
# aes_xif_result_queue

In-order result buffer between the AES coprocessor datapath and the cv32e40x eXtension-interface (XIF) result channel. It accepts finished AES results tagged with the XIF instruction id. It holds each result until the core has committed or killed that id. Committed results go out on the XIF result handshake; killed results are discarded silently.

## Interface
- X_ID_WIDTH, 4, XIF instruction id width; the per-id state vectors are 2**X_ID_WIDTH wide.
- X_RFW_WIDTH, 32, result data width.
- DEPTH, 4, number of queue entries; power of two, minimum 2.

Clocking and reset (already decided): one clock; reset is synchronous and active-high.
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- eng_valid_i  in  1  AES engine result valid.
- eng_ready_o  out  1  queue can accept a result; equals !full && !rst_i.
- eng_id_i  in  X_ID_WIDTH  id of the result.
- eng_rd_i  in  5  destination register.
- eng_we_i  in  1  register write enable.
- eng_data_i  in  X_RFW_WIDTH  result data.
- commit_valid_i  in  1  XIF commit strobe.
- commit_id_i  in  X_ID_WIDTH  id being committed or killed.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- result_valid_o  out  1  XIF result valid.
- result_ready_i  in  1  XIF result ready.
- result_id_o  out  X_ID_WIDTH  result id.
- result_rd_o  out  5  result destination register.
- result_we_o  out  1  result write enable.
- result_data_o  out  X_RFW_WIDTH  result data.
- count_o  out  $clog2(DEPTH+1)  number of occupied entries.

## Operation
- Entries live in a circular FIFO with read and write pointers of width log2(DEPTH)+1. The extra MSB tells full apart from empty, and the pointers wrap modulo 2·DEPTH.
- Push: eng_valid_i && eng_ready_o pushes {id, rd, we, data} at the write pointer.
- When full, eng_ready_o is 0. There is no pop-through while full; a pop in that cycle frees a slot visible in the next cycle.
- Per-id state is held in two vectors, cmt[] and kil[]. When commit_valid_i is high, cmt[commit_id_i] is set to 1 and kil[commit_id_i] is set to commit_kill_i.
- Commits may arrive before or after the matching result, or in the same cycle as it.
- Head state is one of three:
  - WAIT: cmt[head.id] is 0.
  - SEND: cmt is 1 and kil is 0. result_valid_o is 1 and the payload comes from the head entry.
  - DROP: cmt is 1 and kil is 1. The entry is popped internally with result_valid_o at 0.
- Each pop clears cmt and kil for the popped id.
- If a clear and a new commit for the same id fall in the same cycle, the new commit wins.
- Once result_valid_o is 1, it and the payload stay stable until result_ready_i is seen.
- When the queue is empty, result_valid_o is 0 and the payload outputs are 0.
- The XIF rules guarantee two things, and the queue does not check them:
  - An id is not reused until its result has left the queue.
  - An id is committed or killed only once.
- Reset, including mid-operation: pointers, cmt[] and kil[] are all cleared and stored entries are lost. In-flight results are not replayed.

## Timing
- Reset values: result_valid_o 0, all result payload outputs 0, count_o 0, eng_ready_o 0 while rst_i is high and 1 in the first cycle after.
- Latency, push to result_valid_o: 1 cycle minimum, when the commit arrives on or before the push cycle. A commit arriving later gives result_valid_o in the cycle after that commit.
- Throughput: 1 result per cycle when committed and the consumer is always ready.
- DROP costs 1 cycle per killed entry. The next head can be presented in the following cycle.
- Push and pop in the same cycle: count_o is unchanged.

## Configuration
- AES_RESQ_BYPASS_EN defined: when the queue is empty, eng_valid_i is 1, cmt[eng_id_i] is 1 and kil[eng_id_i] is 0, the engine inputs drive the result outputs combinationally with result_valid_o = 1. This gives 0-cycle latency.
  - If result_ready_i is 1 in that cycle, nothing is written to the queue.
  - If result_ready_i is 0, the result is pushed normally and presented from the head in the following cycle.
- AES_RESQ_BYPASS_EN undefined: no combinational path from the eng_* inputs to the result_* outputs; latency follows the Timing section.

## Structure
- Package aes_coproc_pkg holds:
  - typedef aes_res_entry_t {id, rd, we, data}, parameterised via X_ID_WIDTH and X_RFW_WIDTH.
  - localparam RD_WIDTH = 5.
  - the head-state enum {WAIT, SEND, DROP}.
- One sub-module, aes_resq_fifo: a generic synchronous FIFO of aes_res_entry_t with push, pop, head, count, full and empty.
- The commit vectors and head-state logic stay in the top module.

## Test plan
- Push id 3, data 0x0000_00A5, rd 7; then commit id 3 with no kill, ready held high → result_valid_o for one cycle with id 3, rd 7, data 0xA5; count_o returns to 0.
- Commit id 5 first, then push id 5, ready high → result_valid_o in the cycle after the push (bypass undefined); zero-latency in the push cycle with AES_RESQ_BYPASS_EN defined.
- Push ids 1, 2, 3; kill 2; commit 1 and 3 → outputs id 1 then id 3; id 2 never appears on the result outputs.
- Fill to DEPTH=4 with ready low → eng_ready_o 0 and count_o 4. Raise ready → 4 results in 4 cycles; eng_ready_o returns to 1 the cycle after the first pop.
- Result valid with ready low for 5 cycles → payload stable on all 5 cycles.
- Assert rst_i with 3 entries queued and 2 committed → next cycle result_valid_o 0 and count_o 0. A re-push of a previously committed id then waits for a fresh commit.
